// File: rtl/uart_host_pkg.sv
// UART memory host: shared types and opcode constants.
// State encoding for the host FSM plus the opcode frame values.
package uart_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_OP,
    SEND_ADDR,
    SEND_DATA,
    WAIT_RSP,
    RSP
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/uart_host_rx.sv
// UART memory host: serial response receiver.
// Optional busy_o exists only with UART_HOST_TIMEOUT_EN defined.
module uart_host_rx
  import uart_host_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int BAUD_PERIOD = 16
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   en_i,
  input  logic                   rx_i,
`ifdef UART_HOST_TIMEOUT_EN
  output logic                   busy_o,
`endif
  output logic                   done_o,
  output logic                   err_o,
  output logic [FRAME_WIDTH-1:0] data_o
);

  localparam int BW = $clog2(BAUD_PERIOD);
  localparam int NW = $clog2(FRAME_WIDTH + 2);
  localparam logic [BW-1:0] BMAX = BW'(BAUD_PERIOD - 1);
  localparam logic [BW-1:0] HALF = BW'(BAUD_PERIOD / 2 - 1);
  localparam logic [NW-1:0] STOP = NW'(FRAME_WIDTH + 1);

  logic [2:0]             sy_q;
  logic                   act_q, act_d;
  logic [BW-1:0]          cnt_q, cnt_d;
  logic [NW-1:0]          idx_q, idx_d;
  logic [FRAME_WIDTH-1:0] dat_q, dat_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   s;
  logic                   fall;

  assign s      = sy_q[1];
  assign fall   = sy_q[2] & ~sy_q[1];
  assign done_o = done_q;
  assign err_o  = err_q;
  assign data_o = dat_q;
`ifdef UART_HOST_TIMEOUT_EN
  assign busy_o = act_q;
`endif

  // Two-flop synchronizer plus one history flop for edge detect.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) sy_q <= 3'b111;
    else        sy_q <= {sy_q[1:0], rx_i};
  end

  // Start detect, mid-bit sampling and stop-bit check.
  always_comb begin
    act_d  = act_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    dat_d  = dat_q;
    err_d  = err_q;
    done_d = 1'b0;
    if (!en_i) begin
      act_d = 1'b0;
    end else if (!act_q) begin
      if (fall) begin
        act_d = 1'b1;
        cnt_d = '0;
        idx_d = '0;
      end
    end else begin
      cnt_d = (cnt_q == BMAX) ? '0 : cnt_q + 1'b1;
      if (cnt_q == HALF) begin
        if (idx_q == '0) begin
          if (s) act_d = 1'b0;
          else   idx_d = idx_q + 1'b1;
        end else if (idx_q != STOP) begin
          dat_d = dat_q >> 1;
          dat_d[FRAME_WIDTH-1] = s;
          idx_d = idx_q + 1'b1;
        end else begin
          done_d = 1'b1;
          err_d  = ~s;
          act_d  = 1'b0;
        end
      end
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      act_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      dat_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      dat_q  <= dat_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/uart_mem_host.sv
// UART memory host: request FSM and TX serializer.
// Read timeout enabled by defining UART_HOST_TIMEOUT_EN.
module uart_mem_host
  import uart_host_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_PERIOD    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  TX,
  input  logic                  RX,
  output logic                  busy
);

  localparam int FL = FRAME_WIDTH + 2;
  localparam int BW = $clog2(BAUD_PERIOD);
  localparam int NW = $clog2(FL);
  localparam logic [BW-1:0] BMAX = BW'(BAUD_PERIOD - 1);
  localparam logic [NW-1:0] LAST = NW'(FL - 1);

  if (FRAME_WIDTH < ADDR_WIDTH || FRAME_WIDTH < DATA_WIDTH ||
      BAUD_PERIOD < 16) begin : g_bad_cfg
    $fatal(1, "uart_mem_host: illegal parameter set");
  end

  state_e                st_q, st_d;
  logic [FL-1:0]         sh_q, sh_d;
  logic [BW-1:0]         bd_q, bd_d;
  logic [NW-1:0]         nb_q, nb_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] ad_q, ad_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  er_q, er_d;
  logic                  tx_on;
  logic                  fdone;
  logic                  rx_done;
  logic                  rx_err;
  logic [FRAME_WIDTH-1:0] rx_data;

  function automatic logic [FL-1:0] frame(input logic [FRAME_WIDTH-1:0] v);
    return {1'b1, v, 1'b0};
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] op_f(input logic w);
    op_f    = '0;
    op_f[0] = w ? OP_WRITE : OP_READ;
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] ext_a(input logic [ADDR_WIDTH-1:0] a);
    ext_a = '0;
    ext_a[ADDR_WIDTH-1:0] = a;
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] ext_d(input logic [DATA_WIDTH-1:0] d);
    ext_d = '0;
    ext_d[DATA_WIDTH-1:0] = d;
  endfunction

  assign tx_on     = (st_q == SEND_OP) || (st_q == SEND_ADDR) || (st_q == SEND_DATA);
  assign TX        = tx_on ? sh_q[0] : 1'b1;
  assign req_ready = (st_q == IDLE);
  assign busy      = (st_q != IDLE);
  assign rsp_valid = (st_q == RSP);
  assign rsp_rdata = rd_q;
  assign rsp_err   = er_q;

`ifdef UART_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_q;
  logic          rx_busy;
`endif

  uart_host_rx #(
    .FRAME_WIDTH(FRAME_WIDTH),
    .BAUD_PERIOD(BAUD_PERIOD)
  ) u_rx (
    .clk   (clk),
    .rst_l (rst_l),
    .en_i  (st_q == WAIT_RSP),
    .rx_i  (RX),
`ifdef UART_HOST_TIMEOUT_EN
    .busy_o(rx_busy),
`endif
    .done_o(rx_done),
    .err_o (rx_err),
    .data_o(rx_data)
  );

`ifdef UART_HOST_TIMEOUT_EN
  // Response timer: zero outside WAIT_RSP, held while a frame arrives.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                to_q <= '0;
    else if (st_q != WAIT_RSP) to_q <= '0;
    else if (!rx_busy)         to_q <= to_q + 1'b1;
  end
`endif

  // Next state, bit timing and frame loading.
  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    bd_d  = bd_q;
    nb_d  = nb_q;
    wr_d  = wr_q;
    ad_d  = ad_q;
    wd_d  = wd_q;
    rd_d  = rd_q;
    er_d  = er_q;
    fdone = 1'b0;
    if (tx_on) begin
      if (bd_q == BMAX) begin
        bd_d = '0;
        if (nb_q == LAST) begin
          fdone = 1'b1;
        end else begin
          sh_d = {1'b1, sh_q[FL-1:1]};
          nb_d = nb_q + 1'b1;
        end
      end else begin
        bd_d = bd_q + 1'b1;
      end
    end
    unique case (st_q)
      IDLE: if (req_valid) begin
        wr_d = req_wr;
        ad_d = req_addr;
        wd_d = req_wdata;
        sh_d = frame(op_f(req_wr));
        bd_d = '0;
        nb_d = '0;
        st_d = SEND_OP;
      end
      SEND_OP: if (fdone) begin
        sh_d = frame(ext_a(ad_q));
        nb_d = '0;
        st_d = SEND_ADDR;
      end
      SEND_ADDR: if (fdone) begin
        nb_d = '0;
        if (wr_q) begin
          sh_d = frame(ext_d(wd_q));
          st_d = SEND_DATA;
        end else begin
          st_d = WAIT_RSP;
        end
      end
      SEND_DATA: if (fdone) begin
        rd_d = '0;
        er_d = 1'b0;
        st_d = RSP;
      end
      WAIT_RSP: begin
        if (rx_done) begin
          rd_d = rx_data[DATA_WIDTH-1:0];
          er_d = rx_err;
          st_d = RSP;
        end
`ifdef UART_HOST_TIMEOUT_EN
        else if (to_q == TMAX) begin
          rd_d = '0;
          er_d = 1'b1;
          st_d = RSP;
        end
`endif
      end
      RSP: if (rsp_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Host state registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      st_q <= IDLE;
      sh_q <= '1;
      bd_q <= '0;
      nb_q <= '0;
      wr_q <= 1'b0;
      ad_q <= '0;
      wd_q <= '0;
      rd_q <= '0;
      er_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      bd_q <= bd_d;
      nb_q <= nb_d;
      wr_q <= wr_d;
      ad_q <= ad_d;
      wd_q <= wd_d;
      rd_q <= rd_d;
      er_q <= er_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_host.sv
// Bench for uart_mem_host: directed and random transactions.
// Timeout branch follows UART_HOST_TIMEOUT_EN.
module tb_uart_mem_host;

  localparam int BP = 16;
`ifdef UART_HOST_TIMEOUT_EN
  localparam int TO = 1000;
`else
  localparam int TO = 4096;
`endif

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       TX;
  logic       RX = 1'b1;
  logic       busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_mem_host #(
    .FRAME_WIDTH(8),
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .BAUD_PERIOD(BP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .TX(TX),
    .RX(RX),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level k cycles after acceptance for a frame list.
  function automatic logic tx_model(input logic [7:0] f0, input logic [7:0] f1,
                                    input logic [7:0] f2, input int k);
    int fi;
    int bi;
    logic [7:0] v;
    fi = k / (10 * BP);
    bi = (k / BP) % 10;
    v  = (fi == 0) ? f0 : (fi == 1) ? f1 : f2;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return v[bi-1];
  endfunction

  task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d,
                       input string tag);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, {31'd0, req_ready}, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_tx(input logic [7:0] f0, input logic [7:0] f1,
                          input logic [7:0] f2, input int nf,
                          input bit noise, input string tag);
    int errs;
    int early;
    errs  = 0;
    early = 0;
    for (int k = 0; k < nf * 10 * BP; k++) begin
      if (TX !== tx_model(f0, f1, f2, k)) errs++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) early++;
      if (noise) RX = 1'($urandom_range(0, 1));
      step();
    end
    RX = 1'b1;
    chk({tag, "_txwave"}, errs, 0);
    chk({tag, "_early"}, early, 0);
  endtask

  task automatic drive_rx(input logic [7:0] v, input logic stopb);
    for (int b = 0; b < 10; b++) begin
      RX = (b == 0) ? 1'b0 : (b == 9) ? stopb : v[b-1];
      repeat (BP) step();
    end
    RX = 1'b1;
  endtask

  task automatic take_rsp(input logic [7:0] rd, input logic er, input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 1);
    chk({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, rd});
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, er});
    chk({tag, "_noready"}, {31'd0, req_ready}, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_idle"}, {29'd0, rsp_valid, req_ready, busy}, 3'b010);
  endtask

  initial begin
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
    logic       sb;
    int         errs;

    // Reset values.
    #3;
    chk("rst_tx", {31'd0, TX}, 1);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_valid", {31'd0, rsp_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp", {23'd0, rsp_err, rsp_rdata}, 0);
    repeat (3) step();
    rst_l = 1'b1;
    step();

    // Write 0x3 <- 0xA5, RX noise must be ignored.
    issue(1'b1, 4'h3, 8'hA5, "wr");
    check_tx(8'h01, 8'h03, 8'hA5, 3, 1'b1, "wr");
    chk("wr_lat", {31'd0, rsp_valid}, 1);
    take_rsp(8'h00, 1'b0, "wr");

    // Read 0x5, memory answers 0x5A.
    issue(1'b0, 4'h5, 8'h00, "rd");
    check_tx(8'h00, 8'h05, 8'h00, 2, 1'b0, "rd");
    drive_rx(8'h5A, 1'b1);
    take_rsp(8'h5A, 1'b0, "rd");

    // Glitch start ignored, then framing error on 0x33.
    issue(1'b0, 4'h9, 8'h00, "fe");
    check_tx(8'h00, 8'h09, 8'h00, 2, 1'b0, "fe");
    RX = 1'b0;
    repeat (5) step();
    RX = 1'b1;
    repeat (30) step();
    chk("glitch", {30'd0, rsp_valid, busy}, 2'b01);
    drive_rx(8'h33, 1'b0);
    take_rsp(8'h33, 1'b1, "fe");

    // Response stall with a pending request.
    issue(1'b1, 4'h2, 8'h3C, "st");
    check_tx(8'h01, 8'h02, 8'h3C, 3, 1'b0, "st");
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 4'hF;
    req_wdata = 8'hEE;
    errs = 0;
    for (int k = 0; k < 50; k++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0 ||
          req_ready !== 1'b0) errs++;
      step();
    end
    chk("stall", errs, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hs_noaccept", {30'd0, busy, req_ready}, 2'b01);
    req_valid = 1'b0;
    step();
    chk("hs_idle", {31'd0, busy}, 0);

    // Random transactions against the frame/response model.
    for (int i = 0; i < 8; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      issue(wr, a, d, "rnd");
      if (wr) begin
        check_tx(8'h01, {4'h0, a}, d, 3, 1'b1, "rnd_w");
        take_rsp(8'h00, 1'b0, "rnd_w");
      end else begin
        check_tx(8'h00, {4'h0, a}, 8'h00, 2, 1'b0, "rnd_r");
        drive_rx(d, sb);
        take_rsp(d, ~sb, "rnd_r");
      end
    end

    // Reset in the middle of the address frame.
    issue(1'b1, 4'h7, 8'h11, "ar");
    repeat (200) step();
    rst_l = 1'b0;
    #1;
    chk("ar_tx", {31'd0, TX}, 1);
    chk("ar_state", {29'd0, rsp_valid, busy, req_ready}, 3'b001);
    chk("ar_rsp", {23'd0, rsp_err, rsp_rdata}, 0);
    repeat (2) step();
    rst_l = 1'b1;
    errs = 0;
    for (int k = 0; k < 500; k++) begin
      if (rsp_valid !== 1'b0 || TX !== 1'b1) errs++;
      step();
    end
    chk("ar_quiet", errs, 0);
    issue(1'b1, 4'h7, 8'h11, "ar2");
    check_tx(8'h01, 8'h07, 8'h11, 3, 1'b0, "ar2");
    take_rsp(8'h00, 1'b0, "ar2");

    // Silent memory on a read.
    issue(1'b0, 4'h4, 8'h00, "to");
    check_tx(8'h00, 8'h04, 8'h00, 2, 1'b0, "to");
`ifdef UART_HOST_TIMEOUT_EN
    errs = 0;
    for (int k = 1; k < TO; k++) begin
      step();
      if (rsp_valid !== 1'b0) errs++;
    end
    chk("to_early", errs, 0);
    step();
    chk("to_fire", {31'd0, rsp_valid}, 1);
    take_rsp(8'h00, 1'b1, "to");
`else
    errs = 0;
    for (int k = 0; k < 5000; k++) begin
      if (busy !== 1'b1 || rsp_valid !== 1'b0) errs++;
      step();
    end
    chk("hang", errs, 0);
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    step();
    chk("hang_rst", {31'd0, busy}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
